// File: rtl/serial_subtractor_signed.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Start/busy/done handshake; Diff, Bout and V are registered and update only at completion.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// SHIFT | one difference bit per cycle, LSB first, for N cycles
// DONE  | done pulse cycle; its closing edge is also the first idle sample edge
module serial_subtractor_signed #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         V
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  w;
  logic          br;
  logic [CW-1:0] cnt;
  logic          d_bit;
  logic          br_nxt;

  always_comb begin
    d_bit  = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      w     <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The edge ending DONE counts as idle, so held start gives N+1 spacing.
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            cnt   <= '0;
            w     <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          w    <= {d_bit, w[N-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            // br here is the borrow into the MSB; br_nxt the borrow out of it.
            Diff  <= {d_bit, w[N-1:1]};
            Bout  <= br_nxt;
            V     <= br ^ br_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
